// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes, oversampling factor.
// Latency: none (package only).
// Backpressure: not applicable.
package uart_pkg;

  // Ticks per bit period
  localparam int OVS = 16;

  // Parity modes
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  // Rounded clock divider for one oversample tick: round(clk / (baud * OVS))
  function automatic int calc_div(input int clk_freq_hz, input int baud);
    longint den;
    den = longint'(baud) * longint'(OVS);
    return int'((longint'(clk_freq_hz) + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses tick while at DIV-1.
// Latency: tick is combinational from the counter; restart zeroes it on the next edge.
// Backpressure: none, free-running except for the synchronous restart.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counter, realigned to zero when a frame start is detected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A restart cycle never produces a stale tick from the old phase
  assign tick = (cnt == LAST) && !restart;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver (5..9 data bits, none/even/odd parity, 1/2 stop bits); UART_RX_MAJORITY_EN selects 2-of-3 bit voting.
// Latency: word, error flags and rx_valid update one clk after the final stop bit's sample-9 tick.
// Backpressure: rx_valid holds until rx_ready; a new word arriving over an unconsumed one overwrites it and pulses overrun.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 break_det
);

  localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD);

  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  logic                 fall;
  logic                 start_det;
  logic                 tick;
  logic [3:0]           sample_cnt;
  logic                 s8;
  logic                 bit_val;
  logic                 sample_pt;
  rx_state_t            state;
  logic [3:0]           bit_idx;
  logic                 stop_idx;
  logic                 stop1;
  logic                 last_stop;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_pend;
  logic                 exp_par;
  logic                 frame_done;
  logic                 fe_now;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection; idle line is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall      = rx_prev & ~rx_sync;
  assign start_det = (state == ST_IDLE) && fall;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (start_det),
    .tick    (tick)
  );

  // Tick position within the current bit and the mid-bit sample at count 8
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      s8         <= 1'b1;
    end else if (start_det) begin
      sample_cnt <= '0;
    end else if (tick) begin
      sample_cnt <= sample_cnt + 4'd1;
      if (sample_cnt == 4'd8) s8 <= rx_sync;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic s7;

  // Early sample at count 7 for the 2-of-3 vote
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s7 <= 1'b1;
    end else if (tick && (sample_cnt == 4'd7)) begin
      s7 <= rx_sync;
    end
  end

  // Count 9 is taken live from the synchroniser at the decision tick
  assign bit_val = (s7 & s8) | (s7 & rx_sync) | (s8 & rx_sync);
`else
  assign bit_val = s8;
`endif

  // Bit decisions are made at the count-9 tick in both sampling modes
  assign sample_pt  = tick && (sample_cnt == 4'd9);
  assign exp_par    = (PARITY == PAR_ODD) ? ~(^shreg) : ^shreg;
  assign last_stop  = (STOP_BITS == 1) || stop_idx;
  assign frame_done = sample_pt && (state == ST_STOP) && last_stop;
  // Only the first stop bit is checked; with two stop bits it was captured in stop1
  assign fe_now     = (stop_idx == 1'b0) ? ~bit_val : ~stop1;

  // Frame FSM with registered word, error flags and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      stop1      <= 1'b1;
      shreg      <= '0;
      par_pend   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      break_det <= 1'b0;

      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      // A completion always wins; same-cycle consumption of the old word avoids an overrun
      if (frame_done) begin
        rx_data    <= shreg;
        parity_err <= par_pend;
        frame_err  <= fe_now;
        rx_valid   <= 1'b1;
        overrun    <= rx_valid && !rx_ready;
        break_det  <= (shreg == '0) && fe_now;
      end

      case (state)
        ST_IDLE: begin
          if (start_det) begin
            state    <= ST_START;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
          end
        end

        ST_START: begin
          if (sample_pt) begin
            if (!bit_val) begin
              state    <= ST_DATA;
              bit_idx  <= '0;
              par_pend <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        ST_DATA: begin
          if (sample_pt) begin
            shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            if (bit_idx == 4'(DATA_BITS - 1)) begin
              state    <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end

        ST_PARITY: begin
          if (sample_pt) begin
            par_pend <= (bit_val != exp_par);
            state    <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (sample_pt) begin
            if (!stop_idx) stop1 <= bit_val;
            if (last_stop) begin
              state <= fe_now ? ST_WAIT_HIGH : ST_IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end

        ST_WAIT_HIGH: begin
          // A held-low line (break) must return high before another start can be seen
          if (rx_sync) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
